// File: rtl/md_issue_ctrl_if.sv
// Pipeline/MD-unit bundle for md_issue_ctrl: request handshake, MD unit drive/return, read response.
// The master side is the pipeline plus MD unit; the slave side is the issue controller.
interface md_issue_ctrl_if;
  logic        req_valid;
  logic [3:0]  req_sel;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        req_ready;
  logic        stall;
  logic        md_start;
  logic [3:0]  md_sel;
  logic [31:0] md_a;
  logic [31:0] md_b;
  logic        md_busy;
  logic [31:0] md_out;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        timeout_err;

  modport master (
    output req_valid, req_sel, req_a, req_b, md_busy, md_out,
    input  req_ready, stall, md_start, md_sel, md_a, md_b, rsp_valid, rsp_data, timeout_err
  );

  modport slave (
    input  req_valid, req_sel, req_a, req_b, md_busy, md_out,
    output req_ready, stall, md_start, md_sel, md_a, md_b, rsp_valid, rsp_data, timeout_err
  );
endinterface

// File: rtl/md_issue_ctrl.sv
// E-stage issue controller for the HI/LO multiply/divide unit: one op at a time, stall while busy.
// Optional MD_PERF_EN adds perf_stall_cnt / perf_op_cnt counters.
module md_issue_ctrl #(
  parameter int unsigned MAX_WAIT = 16,
  parameter int unsigned CNT_W    = 5
) (
  input  logic           clk,
  input  logic           reset,
  md_issue_ctrl_if.slave bus
`ifdef MD_PERF_EN
  ,
  output logic [31:0]    perf_stall_cnt,
  output logic [31:0]    perf_op_cnt
`endif
);

  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_e;

  state_e            state_q, state_d;
  logic [SW-1:0]     sel_q, sel_d;
  logic [DW-1:0]     a_q, a_d;
  logic [DW-1:0]     b_q, b_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic              err_q, err_d;
  logic [DW-1:0]     rsp_data_q, rsp_data_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              req_ready_q, req_ready_d;
  logic              md_start_q, md_start_d;
  logic [SW-1:0]     md_sel_q, md_sel_d;
  logic [DW-1:0]     md_a_q, md_a_d;
  logic [DW-1:0]     md_b_q, md_b_d;
  logic              stall_c;
  logic              accept_op_c;

  function automatic logic sel_legal(input logic [SW-1:0] s);
    return (s >= SW'(1)) && (s <= SW'(8));
  endfunction

  function automatic logic sel_arith(input logic [SW-1:0] s);
    return (s >= SW'(1)) && (s <= SW'(4));
  endfunction

  assign stall_c     = bus.req_valid & ~req_ready_q;
  assign accept_op_c = bus.req_valid & req_ready_q & sel_legal(bus.req_sel);

  // Next state, latches, and registered outputs derived from the next state
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    a_d         = a_q;
    b_d         = b_q;
    cnt_d       = '0;
    cnt_inc     = cnt_q + CNT_W'(1);
    err_d       = err_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept_op_c) begin
          sel_d   = bus.req_sel;
          a_d     = bus.req_a;
          b_d     = bus.req_b;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = sel_arith(sel_q) ? S_WAIT : S_IDLE;
        if ((sel_q == SW'(5)) || (sel_q == SW'(6))) begin
          rsp_data_d  = bus.md_out;
          rsp_valid_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (!bus.md_busy) begin
          state_d = S_IDLE;
        end else if (cnt_inc == CNT_W'(MAX_WAIT)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // MD drive is zero outside ISSUE so HI/LO never see a stray mthi/mtlo
    req_ready_d = (state_d == S_IDLE);
    md_start_d  = (state_d == S_ISSUE) && sel_arith(sel_d);
    md_sel_d    = (state_d == S_ISSUE) ? sel_d : '0;
    md_a_d      = (state_d == S_ISSUE) ? a_d   : '0;
    md_b_d      = (state_d == S_ISSUE) ? b_d   : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      sel_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      req_ready_q <= 1'b1;
      md_start_q  <= 1'b0;
      md_sel_q    <= '0;
      md_a_q      <= '0;
      md_b_q      <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      req_ready_q <= req_ready_d;
      md_start_q  <= md_start_d;
      md_sel_q    <= md_sel_d;
      md_a_q      <= md_a_d;
      md_b_q      <= md_b_d;
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.stall       = stall_c;
  assign bus.md_start    = md_start_q;
  assign bus.md_sel      = md_sel_q;
  assign bus.md_a        = md_a_q;
  assign bus.md_b        = md_b_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.timeout_err = err_q;

`ifdef MD_PERF_EN
  logic [31:0] perf_stall_cnt_q, perf_stall_cnt_d;
  logic [31:0] perf_op_cnt_q, perf_op_cnt_d;

  // Free-running event counters; wrap naturally at 2^32
  always_comb begin
    perf_stall_cnt_d = perf_stall_cnt_q;
    perf_op_cnt_d    = perf_op_cnt_q;
    if (stall_c)     perf_stall_cnt_d = perf_stall_cnt_q + 32'd1;
    if (accept_op_c) perf_op_cnt_d    = perf_op_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_cnt_q <= '0;
      perf_op_cnt_q    <= '0;
    end else begin
      perf_stall_cnt_q <= perf_stall_cnt_d;
      perf_op_cnt_q    <= perf_op_cnt_d;
    end
  end

  assign perf_stall_cnt = perf_stall_cnt_q;
  assign perf_op_cnt    = perf_op_cnt_q;
`endif

endmodule
